// File: rtl/sbox_sub_bytes_seq.sv
// Forward AES SubBytes engine: one 128-bit state in, BYTES_PER_CYCLE S-box lanes, result held until taken.
// Optional macro SBOX_PIPE_EN registers the lane inputs and applies the S-box one cycle later (PIPE state).
module sbox_sub_bytes_seq #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    localparam int BPC    = BYTES_PER_CYCLE;
    localparam int NCHUNK = 16 / BPC;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    generate
        if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8 || BPC == 16)) begin : g_bad_bpc
            $error("sbox_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    // Byte 0 sits in the top bits, so lane l of chunk c lands at bit 8*(15 - (c*BPC + l)).
    function automatic logic [6:0] lane_lsb(input logic [CNT_W-1:0] c, input int l);
        return 7'(8 * (15 - (int'(c) * BPC + l)));
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        PIPE = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [127:0]     work_q;
    logic [7:0]       lane_in  [BPC];
    logic [7:0]       lane_out [BPC];
    logic             accept;

    assign accept = (state_q == IDLE) && in_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
`ifdef SBOX_PIPE_EN
                    state_d = PIPE;
`else
                    state_d = DONE;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PIPE: state_d = DONE;
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        for (int l = 0; l < BPC; l++) begin
            lane_in[l] = work_q[lane_lsb(cnt_q, l) +: 8];
        end
    end

`ifdef SBOX_PIPE_EN
    logic [7:0]       lane_p0 [BPC];
    logic [CNT_W-1:0] idx_p0;
    logic             vld_p0;

    // Stage p0: chunk selected in BUSY, S-box applied and written back one cycle later.
    always_ff @(posedge clk) begin
        if (rst) vld_p0 <= 1'b0;
        else     vld_p0 <= (state_q == BUSY);
        lane_p0 <= lane_in;
        idx_p0  <= cnt_q;
    end

    always_comb begin
        for (int l = 0; l < BPC; l++) begin
            lane_out[l] = sbox(lane_p0[l]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work_q <= '0;
        end else if (accept) begin
            work_q <= in_state;
        end else if (vld_p0) begin
            for (int l = 0; l < BPC; l++) begin
                work_q[lane_lsb(idx_p0, l) +: 8] <= lane_out[l];
            end
        end
    end

    assign busy = (state_q == BUSY) || (state_q == PIPE);
`else
    always_comb begin
        for (int l = 0; l < BPC; l++) begin
            lane_out[l] = sbox(lane_in[l]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work_q <= '0;
        end else if (accept) begin
            work_q <= in_state;
        end else if (state_q == BUSY) begin
            for (int l = 0; l < BPC; l++) begin
                work_q[lane_lsb(cnt_q, l) +: 8] <= lane_out[l];
            end
        end
    end

    assign busy = (state_q == BUSY);
`endif

    // Ready is masked by rst so no handshake is offered while reset is held.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign out_state = work_q;

endmodule

// File: tb/tb_sbox_sub_bytes_seq.sv
// Scoreboard bench for sbox_sub_bytes_seq: driver queues expected results, a negedge monitor checks them.
module tb_sbox_sub_bytes_seq;
    localparam int BPC    = 4;
    localparam int NCHUNK = 16 / BPC;
`ifdef SBOX_PIPE_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif
    localparam int LAT = NCHUNK + PIPE;
    localparam int SW_BPC [3] = '{1, 2, 16};

    localparam logic [127:0] VEC1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] EXP1 = 128'h638293c31bfc33f5c4eeacea4bc12816;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    logic         sw_valid;
    logic [127:0] sw_state;
    logic [2:0]   sw_in_ready, sw_out_valid, sw_busy;
    logic [127:0] sw_out_state [3];

    always #5 clk = ~clk;

    sbox_sub_bytes_seq #(.BYTES_PER_CYCLE(BPC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .busy(busy)
    );

    for (genvar g = 0; g < 3; g++) begin : g_sw
        sbox_sub_bytes_seq #(.BYTES_PER_CYCLE(SW_BPC[g])) u_sw (
            .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_in_ready[g]), .in_state(sw_state),
            .out_valid(sw_out_valid[g]), .out_ready(1'b1), .out_state(sw_out_state[g]), .busy(sw_busy[g])
        );
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [127:0] d;
        int           acc;
    } exp_t;
    exp_t         sbq [$];
    logic         holding = 1'b0;
    logic [127:0] held;
    int           last_acc = 0;
    int           last_acc_prev = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference S-box built from GF(2^8) inversion and the affine map.
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_m(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        logic [7:0] s;
        for (int i = 0; i < 254; i++) r = gmul(r, x);
        s = r;
        for (int k = 1; k <= 4; k++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_m(input logic [127:0] st);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_m(st[8*i +: 8]);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves in_valid high; the caller decides whether another state follows.
    task automatic send(input logic [127:0] s, input logic [127:0] exp);
        int   k = 0;
        exp_t e;
        in_valid = 1'b1;
        in_state = s;
        while (!in_ready && k < 100) begin
            step();
            k++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles, expected 1", k);
        end else begin
            e.d = exp;
            e.acc = cyc + 1;
            sbq.push_back(e);
            last_acc_prev = last_acc;
            last_acc = e.acc;
        end
        step();
    endtask

    task automatic drain(input string nm);
        int k = 0;
        while ((sbq.size() != 0 || holding || out_valid) && k < 300) begin
            step();
            k++;
        end
        chk(nm, 128'(sbq.size()), 128'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sbq.delete();
                holding = 1'b0;
            end else if (out_valid) begin
                if (!holding) begin
                    if (sbq.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got %h, expected no output", out_state);
                    end else begin
                        e = sbq.pop_front();
                        chk("out_state", out_state, e.d);
                        chk("latency", 128'(cyc - e.acc), 128'(LAT));
                    end
                    held = out_state;
                    holding = 1'b1;
                end else begin
                    chk("hold_stable", out_state, held);
                end
                if (out_ready) holding = 1'b0;
            end else if (holding) begin
                n_checks++;
                n_fail++;
                $display("FAIL valid_dropped: out_valid 0 before handshake, expected 1");
                holding = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [127:0] st;
        int           hs;
        int           t0;
        logic [2:0]   done;

        rst = 1'b1; in_valid = 1'b0; in_state = '0; out_ready = 1'b1;
        sw_valid = 1'b0; sw_state = '0;
        repeat (3) step();
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_out_state", out_state, 128'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 128'(in_ready), 128'd1);

        // Known vectors with hand-computed images
        send(VEC1, EXP1);
        send({16{8'h53}}, {16{8'hed}});
        send({16{8'hff}}, {16{8'h16}});
        in_valid = 1'b0;
        drain("drain_known");

        // Every byte value 00..ff through the S-box
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) st[127 - 8*j -: 8] = 8'(16*i + j);
            send(st, sub_m(st));
        end
        in_valid = 1'b0;
        drain("drain_exhaustive");

        // Backpressure: output held 10 cycles while a new state waits
        out_ready = 1'b0;
        send(VEC1, EXP1);
        in_state = {16{8'h00}};
        for (int k = 0; k < 50 && !out_valid; k++) step();
        chk("bp_out_valid", 128'(out_valid), 128'd1);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("bp_in_ready", 128'(in_ready), 128'd0);
            chk("bp_valid_held", 128'(out_valid), 128'd1);
        end
        out_ready = 1'b1;
        step();
        hs = cyc;
        chk("bp_after_hs_valid", 128'(out_valid), 128'd0);
        chk("bp_after_hs_ready", 128'(in_ready), 128'd1);
        send({16{8'h00}}, {16{8'h63}});
        chk("bp_next_accept", 128'(last_acc - hs), 128'd1);
        in_valid = 1'b0;
        drain("drain_bp");

        // Reset on the second BUSY cycle
        send({16{8'hff}}, {16{8'h16}});
        in_valid = 1'b0;
        step();
        chk("mid_busy", 128'(busy), 128'd1);
        rst = 1'b1;
        step();
        chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        chk("mid_rst_out_state", out_state, 128'd0);
        chk("mid_rst_in_ready", 128'(in_ready), 128'd0);
        step();
        rst = 1'b0;
        #1;
        chk("mid_post_rst_ready", 128'(in_ready), 128'd1);
        send({16{8'h00}}, {16{8'h63}});
        in_valid = 1'b0;
        drain("drain_rst");

        // Back-to-back with in_valid held high
        send(VEC1, EXP1);
        send({16{8'h53}}, {16{8'hed}});
        chk("b2b_spacing1", 128'(last_acc - last_acc_prev), 128'(NCHUNK + 2 + PIPE));
        send({16{8'h00}}, {16{8'h63}});
        chk("b2b_spacing2", 128'(last_acc - last_acc_prev), 128'(NCHUNK + 2 + PIPE));
        in_valid = 1'b0;
        drain("drain_b2b");

        // Lane-count sweep on the side instances
        for (int i = 0; i < 3; i++) chk("sw_in_ready", 128'(sw_in_ready[i]), 128'd1);
        sw_state = VEC1;
        sw_valid = 1'b1;
        step();
        t0 = cyc;
        sw_valid = 1'b0;
        done = 3'b000;
        for (int k = 0; k < 40 && done != 3'b111; k++) begin
            for (int i = 0; i < 3; i++) begin
                if (!done[i] && sw_out_valid[i]) begin
                    chk("sw_out_state", sw_out_state[i], EXP1);
                    chk("sw_latency", 128'(cyc - t0), 128'(16 / SW_BPC[i] + PIPE));
                    done[i] = 1'b1;
                end
            end
            step();
        end
        chk("sw_all_done", 128'(done), 128'd7);
        step();
        chk("sw_idle", 128'(sw_busy), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
